corejtagdebug_tunnel_fsm: RTL and testbench

Per-target tunnel controller for the JTAG debug bridge. It sits directly downstream of the UJTAG macro: it decodes tunnel packets shifted through the user DR while UIREG holds this target's IR code. From each packet it generates a gated TCK plus TMS/TDI sequences that drive one debug target's TAP through a complete IR or DR scan. Target TDO is returned on UTDO with a UTDODRV qualifier, and the parent ORs these across targets.

---
 rtl/corejtagdebug_tunnel_fsm_if.sv | 31 +++
 rtl/corejtagdebug_tunnel_fsm.sv | 196 +++++++++++++++++++
 tb/tb_corejtagdebug_tunnel_fsm.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corejtagdebug_tunnel_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : corejtagdebug_tunnel_fsm_if
// Purpose  : UJTAG-side host strobes/data and target-side TAP pins for one
//            tunnel target.
// Revision : 1.0
// ============================================================================
interface corejtagdebug_tunnel_fsm_if;
    logic       UDRCAP;
    logic       UDRSH;
    logic       UDRUPD;
    logic [7:0] UIREG;
    logic       UTDI;
    logic       DUT_TDO;
    logic       UTDO;
    logic       UTDODRV;
    logic       DUT_TCK;
    logic       DUT_TMS;
    logic       DUT_TDI;

    modport master (
        output UDRCAP, UDRSH, UDRUPD, UIREG, UTDI, DUT_TDO,
        input  UTDO, UTDODRV, DUT_TCK, DUT_TMS, DUT_TDI
    );

    modport slave (
        input  UDRCAP, UDRSH, UDRUPD, UIREG, UTDI, DUT_TDO,
        output UTDO, UTDODRV, DUT_TCK, DUT_TMS, DUT_TDI
    );
endinterface
`default_nettype wire

// File: rtl/corejtagdebug_tunnel_fsm.sv
`default_nettype none
// ============================================================================
// Module   : corejtagdebug_tunnel_fsm
// Purpose  : Decodes tunnel packets from the UJTAG user DR and replays them
//            as a gated-TCK IR/DR scan on one downstream target TAP.
// Revision : 1.0
// ============================================================================
module corejtagdebug_tunnel_fsm #(
    parameter logic [7:0] IR_CODE_TGT       = 8'h55,
    parameter logic [7:0] NUM_LEAD_PAD_BITS = 8'd0
) (
    input  wire logic                    UDRCK,
    input  wire logic                    URSTB,
    corejtagdebug_tunnel_fsm_if.slave    bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PAD  = 3'd1;
    localparam logic [2:0] S_KIND = 3'd2;
    localparam logic [2:0] S_LEN  = 3'd3;
    localparam logic [2:0] S_NAV  = 3'd4;
    localparam logic [2:0] S_PAY  = 3'd5;
    localparam logic [2:0] S_POST = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [7:0] c_pad_last = NUM_LEAD_PAD_BITS - 8'd1;

    logic [2:0] r_state, w_state_d;
    logic [7:0] r_cnt,   w_cnt_d;
    logic [6:0] r_len,   w_len_d;
    logic       r_kind,  w_kind_d;
    logic       r_tms,   w_tms_d;
    logic       r_tdi,   w_tdi_d;
    logic       r_tck_req, w_tck_req_d;
    logic       r_en_q;
    logic       r_tdo;

    logic       w_sel, w_host_bit, w_upd;
    logic [6:0] w_len_shift;
    logic [7:0] w_nav_last;
    logic       w_pay_last;

    assign w_sel       = (bus.UIREG == IR_CODE_TGT);
    assign w_host_bit  = w_sel & bus.UDRSH;
    assign w_upd       = w_sel & bus.UDRUPD;
    assign w_len_shift = {bus.UTDI, r_len[6:1]};
    assign w_nav_last  = r_kind ? 8'd3 : 8'd2;
    assign w_pay_last  = (r_cnt[6:0] == (r_len - 7'd1));

    // State and packet-field registers
    always_ff @(posedge UDRCK or negedge URSTB) begin
        if (!URSTB) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_len     <= 7'd0;
            r_kind    <= 1'b0;
            r_tms     <= 1'b0;
            r_tdi     <= 1'b0;
            r_tck_req <= 1'b0;
            r_tdo     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_len     <= w_len_d;
            r_kind    <= w_kind_d;
            r_tms     <= w_tms_d;
            r_tdi     <= w_tdi_d;
            r_tck_req <= w_tck_req_d;
            r_tdo     <= bus.DUT_TDO;
        end
    end

    // Enable changes only while UDRCK is low, so the gated clock cannot glitch
    always_ff @(negedge UDRCK or negedge URSTB) begin
        if (!URSTB) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= r_tck_req;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_len_d   = r_len;
        w_kind_d  = r_kind;
        if (w_upd) begin
            w_state_d = S_IDLE;
            w_cnt_d   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel && bus.UDRCAP) begin
                        w_cnt_d   = 8'd0;
                        w_state_d = (NUM_LEAD_PAD_BITS == 8'd0) ? S_KIND : S_PAD;
                    end
                end
                S_PAD: begin
                    if (w_host_bit) begin
                        if (r_cnt == c_pad_last) begin
                            w_state_d = S_KIND;
                            w_cnt_d   = 8'd0;
                        end else begin
                            w_cnt_d = r_cnt + 8'd1;
                        end
                    end
                end
                S_KIND: begin
                    if (w_host_bit) begin
                        w_kind_d  = bus.UTDI;
                        w_state_d = S_LEN;
                        w_cnt_d   = 8'd0;
                    end
                end
                S_LEN: begin
                    if (w_host_bit) begin
                        w_len_d = w_len_shift;
                        if (r_cnt == 8'd6) begin
                            w_cnt_d   = 8'd0;
                            w_state_d = (w_len_shift == 7'd0) ? S_DONE : S_NAV;
                        end else begin
                            w_cnt_d = r_cnt + 8'd1;
                        end
                    end
                end
                S_NAV: begin
                    if (w_host_bit) begin
                        if (r_cnt == w_nav_last) begin
                            w_state_d = S_PAY;
                            w_cnt_d   = 8'd0;
                        end else begin
                            w_cnt_d = r_cnt + 8'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (w_host_bit) begin
                        if (w_pay_last) begin
                            w_state_d = S_POST;
                            w_cnt_d   = 8'd0;
                        end else begin
                            w_cnt_d = r_cnt + 8'd1;
                        end
                    end
                end
                S_POST: begin
                    if (w_host_bit) begin
                        if (r_cnt == 8'd1) begin
                            w_state_d = S_DONE;
                            w_cnt_d   = 8'd0;
                        end else begin
                            w_cnt_d = r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Target-cycle generation: TMS walks RTI -> Shift -> Exit1 -> Update -> RTI
    always_comb begin
        w_tck_req_d = 1'b0;
        w_tms_d     = r_tms;
        w_tdi_d     = r_tdi;
        if (w_host_bit && !w_upd) begin
            case (r_state)
                S_NAV: begin
                    w_tck_req_d = 1'b1;
                    w_tms_d     = r_kind ? (r_cnt < 8'd2) : (r_cnt == 8'd0);
                end
                S_PAY: begin
                    w_tck_req_d = 1'b1;
                    w_tms_d     = w_pay_last;
                    w_tdi_d     = bus.UTDI;
                end
                S_POST: begin
                    w_tck_req_d = 1'b1;
                    w_tms_d     = (r_cnt == 8'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.DUT_TCK = UDRCK & r_en_q;
    assign bus.DUT_TMS = r_tms;
    assign bus.DUT_TDI = r_tdi;
    assign bus.UTDO    = r_tdo;
    assign bus.UTDODRV = w_host_bit;

endmodule
`default_nettype wire

// File: tb/tb_corejtagdebug_tunnel_fsm.sv
`default_nettype none
// Bench for corejtagdebug_tunnel_fsm: random tunnel packets compared against a
// packet-level model of the expected target TMS/TDI pulse train and TDO return.
module tb_corejtagdebug_tunnel_fsm;

    logic       UDRCK = 1'b0;
    logic       URSTB = 1'b0;
    logic       udrcap = 1'b0, udrsh = 1'b0, udrupd = 1'b0, utdi = 1'b0, dut_tdo = 1'b0;
    logic [7:0] uireg_a = 8'h55, uireg_b = 8'h00;
    bit         cur = 1'b0;

    int checks = 0;
    int errors = 0;

    bit cap_utdo[$], cap_drv[$], lg_tms[$], lg_tdi[$], lg_tdo[$];
    int exp_tms[$], exp_tdi[$];
    int pc_a = 0, pc_b = 0;
    int pause_extra = 0;
    bit s_tms, s_tdi;

    corejtagdebug_tunnel_fsm_if if_a ();
    corejtagdebug_tunnel_fsm_if if_b ();

    assign if_a.UDRCAP = udrcap;  assign if_b.UDRCAP = udrcap;
    assign if_a.UDRSH  = udrsh;   assign if_b.UDRSH  = udrsh;
    assign if_a.UDRUPD = udrupd;  assign if_b.UDRUPD = udrupd;
    assign if_a.UTDI   = utdi;    assign if_b.UTDI   = utdi;
    assign if_a.DUT_TDO = dut_tdo; assign if_b.DUT_TDO = dut_tdo;
    assign if_a.UIREG  = uireg_a; assign if_b.UIREG  = uireg_b;

    corejtagdebug_tunnel_fsm #(.IR_CODE_TGT(8'h55), .NUM_LEAD_PAD_BITS(8'd0)) u_dut_a (
        .UDRCK(UDRCK), .URSTB(URSTB), .bus(if_a));
    corejtagdebug_tunnel_fsm #(.IR_CODE_TGT(8'h55), .NUM_LEAD_PAD_BITS(8'd3)) u_dut_b (
        .UDRCK(UDRCK), .URSTB(URSTB), .bus(if_b));

    logic m_tck, m_tms, m_tdi, m_utdo, m_drv;
    assign m_tck  = cur ? if_b.DUT_TCK : if_a.DUT_TCK;
    assign m_tms  = cur ? if_b.DUT_TMS : if_a.DUT_TMS;
    assign m_tdi  = cur ? if_b.DUT_TDI : if_a.DUT_TDI;
    assign m_utdo = cur ? if_b.UTDO    : if_a.UTDO;
    assign m_drv  = cur ? if_b.UTDODRV : if_a.UTDODRV;

    always #5 UDRCK = ~UDRCK;

    // Pin values seen by the target at the next rising TCK
    always @(negedge UDRCK) begin
        s_tms = m_tms;
        s_tdi = m_tdi;
    end

    always @(posedge UDRCK) begin
        #2;
        if (if_a.DUT_TCK === 1'b1) pc_a++;
        if (if_b.DUT_TCK === 1'b1) pc_b++;
        if (m_tck === 1'b1) begin
            lg_tms.push_back(s_tms);
            lg_tdi.push_back(s_tdi);
        end
    end

    // Target model: a fresh TDO bit after every falling TCK
    always @(negedge m_tck) begin
        dut_tdo = 1'($urandom);
        lg_tdo.push_back(dut_tdo);
    end

    task automatic cyc(input bit sh, input bit cap, input bit upd, input bit d);
        @(negedge UDRCK);
        udrsh = sh; udrcap = cap; udrupd = upd; utdi = d;
        @(posedge UDRCK);
        #3;
    endtask

    function automatic void make_model(input bit kind, input int len, input bit [127:0] pay);
        exp_tms.delete();
        exp_tdi.delete();
        if (len == 0) return;
        exp_tms.push_back(1); exp_tdi.push_back(2);
        if (kind) begin exp_tms.push_back(1); exp_tdi.push_back(2); end
        exp_tms.push_back(0); exp_tdi.push_back(2);
        exp_tms.push_back(0); exp_tdi.push_back(2);
        for (int k = 0; k < len; k++) begin
            exp_tms.push_back(int'(k == len - 1));
            exp_tdi.push_back(int'(pay[k]));
        end
        exp_tms.push_back(1); exp_tdi.push_back(2);
        exp_tms.push_back(0); exp_tdi.push_back(2);
    endfunction

    task automatic drive_packet(input int pad, input bit kind, input int len,
                                input bit [127:0] pay, input int pause_after, input bit capture);
        bit bits[$];
        logic [6:0] l7;
        int p0;
        l7 = 7'(len);
        for (int i = 0; i < pad; i++) bits.push_back(1'($urandom));
        bits.push_back(kind);
        for (int j = 0; j < 7; j++) bits.push_back(l7[j]);
        if (len > 0) begin
            for (int i = 0; i < (kind ? 4 : 3); i++) bits.push_back(1'($urandom));
            for (int k = 0; k < len; k++) bits.push_back(pay[k]);
            for (int i = 0; i < 5; i++) bits.push_back(1'($urandom));
        end else begin
            for (int i = 0; i < 8; i++) bits.push_back(1'($urandom));
        end
        cap_utdo.delete(); cap_drv.delete();
        lg_tms.delete(); lg_tdi.delete(); lg_tdo.delete();
        pause_extra = 0;
        if (capture) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        foreach (bits[i]) begin
            cyc(1'b1, 1'b0, 1'b0, bits[i]);
            cap_utdo.push_back(m_utdo);
            cap_drv.push_back(m_drv);
            if (i == pause_after) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0);
                p0 = cur ? pc_b : pc_a;
                repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
                pause_extra = (cur ? pc_b : pc_a) - p0;
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        udrsh = 1'b1;
        #12;
        checks++; if (if_a.DUT_TCK !== 1'b0) begin errors++; $display("FAIL reset_tck got %b exp 0", if_a.DUT_TCK); end
        checks++; if (if_a.DUT_TMS !== 1'b0) begin errors++; $display("FAIL reset_tms got %b exp 0", if_a.DUT_TMS); end
        checks++; if (if_a.DUT_TDI !== 1'b0) begin errors++; $display("FAIL reset_tdi got %b exp 0", if_a.DUT_TDI); end
        checks++; if (if_a.UTDO !== 1'b0) begin errors++; $display("FAIL reset_utdo got %b exp 0", if_a.UTDO); end
        checks++; if (if_a.UTDODRV !== 1'b1) begin errors++; $display("FAIL reset_drv_hi got %b exp 1", if_a.UTDODRV); end
        udrsh = 1'b0;
        #1;
        checks++; if (if_a.UTDODRV !== 1'b0) begin errors++; $display("FAIL reset_drv_lo got %b exp 0", if_a.UTDODRV); end
        @(negedge UDRCK);
        URSTB = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dr_scan();
        bit kind; int len, nav; bit [127:0] pay;
        cur = 1'b0; uireg_a = 8'h55; uireg_b = 8'h00;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin kind = 1'b0; len = 5; pay = 128'b10110; end
            else begin
                kind = 1'($urandom); len = $urandom_range(1, 12);
                pay = {$urandom, $urandom, $urandom, $urandom};
            end
            nav = kind ? 4 : 3;
            drive_packet(0, kind, len, pay, -1, 1'b1);
            make_model(kind, len, pay);
            checks++;
            if (lg_tms.size() !== exp_tms.size()) begin
                errors++; $display("FAIL scan_pulses it=%0d got %0d exp %0d", it, lg_tms.size(), exp_tms.size());
            end else begin
                for (int p = 0; p < exp_tms.size(); p++) begin
                    checks++;
                    if (lg_tms[p] !== exp_tms[p][0] || (exp_tdi[p] != 2 && lg_tdi[p] !== exp_tdi[p][0])) begin
                        errors++; $display("FAIL scan_pin it=%0d pulse %0d tms/tdi got %b/%b exp %0d/%0d",
                                           it, p, lg_tms[p], lg_tdi[p], exp_tms[p], exp_tdi[p]);
                    end
                end
                for (int k = 0; k < len; k++) begin
                    checks++;
                    if (cap_utdo[8 + nav + k + 2] !== lg_tdo[nav + k]) begin
                        errors++; $display("FAIL scan_utdo it=%0d bit %0d got %b exp %b",
                                           it, k, cap_utdo[8 + nav + k + 2], lg_tdo[nav + k]);
                    end
                end
            end
        end
    endtask

    task automatic test_ir_pad();
        bit kind; int len, nav; bit [127:0] pay;
        cur = 1'b1; uireg_a = 8'h00; uireg_b = 8'h55;
        for (int it = 0; it < 3; it++) begin
            if (it == 0) begin kind = 1'b1; len = 5; end
            else begin kind = 1'($urandom); len = $urandom_range(1, 10); end
            pay = {$urandom, $urandom, $urandom, $urandom};
            nav = kind ? 4 : 3;
            drive_packet(3, kind, len, pay, -1, 1'b1);
            make_model(kind, len, pay);
            checks++;
            if (lg_tms.size() !== exp_tms.size()) begin
                errors++; $display("FAIL pad_pulses it=%0d got %0d exp %0d", it, lg_tms.size(), exp_tms.size());
            end else begin
                for (int p = 0; p < exp_tms.size(); p++) begin
                    checks++;
                    if (lg_tms[p] !== exp_tms[p][0] || (exp_tdi[p] != 2 && lg_tdi[p] !== exp_tdi[p][0])) begin
                        errors++; $display("FAIL pad_pin it=%0d pulse %0d tms/tdi got %b/%b exp %0d/%0d",
                                           it, p, lg_tms[p], lg_tdi[p], exp_tms[p], exp_tdi[p]);
                    end
                end
                for (int k = 0; k < len; k++) begin
                    checks++;
                    if (cap_utdo[3 + 8 + nav + k + 2] !== lg_tdo[nav + k]) begin
                        errors++; $display("FAIL pad_utdo it=%0d bit %0d got %b exp %b",
                                           it, k, cap_utdo[3 + 8 + nav + k + 2], lg_tdo[nav + k]);
                    end
                end
            end
        end
        cur = 1'b0; uireg_a = 8'h55; uireg_b = 8'h00;
    endtask

    task automatic test_len_zero();
        int ones;
        drive_packet(0, 1'($urandom), 0, '0, -1, 1'b1);
        checks++;
        if (lg_tms.size() !== 0) begin errors++; $display("FAIL len0_pulses got %0d exp 0", lg_tms.size()); end
        ones = 0;
        foreach (cap_drv[i]) ones += int'(cap_drv[i]);
        checks++;
        if (ones !== cap_drv.size()) begin errors++; $display("FAIL len0_drv high %0d of %0d", ones, cap_drv.size()); end
    endtask

    task automatic test_unselected();
        int pa0, pb0, ones;
        pa0 = pc_a; pb0 = pc_b;
        uireg_a = 8'h00;
        drive_packet(0, 1'b0, 5, 128'h1f, -1, 1'b1);
        ones = 0;
        foreach (cap_drv[i]) ones += int'(cap_drv[i]);
        checks++;
        if (ones !== 0) begin errors++; $display("FAIL unsel_drv got %0d high exp 0", ones); end
        checks++;
        if (pc_a - pa0 !== 0 || pc_b - pb0 !== 0) begin
            errors++; $display("FAIL unsel_pulses got a=%0d b=%0d exp 0", pc_a - pa0, pc_b - pb0);
        end
        uireg_a = 8'h55;
        drive_packet(0, 1'b0, 5, 128'h1f, -1, 1'b0);
        checks++;
        if (lg_tms.size() !== 0) begin errors++; $display("FAIL unsel_idle pulses got %0d exp 0", lg_tms.size()); end
    endtask

    task automatic test_pause();
        bit [127:0] pay;
        pay = {$urandom, $urandom, $urandom, $urandom};
        drive_packet(0, 1'b0, 6, pay, 8 + 3 + 2, 1'b1);
        make_model(1'b0, 6, pay);
        checks++;
        if (pause_extra !== 0) begin errors++; $display("FAIL pause_quiet got %0d pulses exp 0", pause_extra); end
        checks++;
        if (lg_tms.size() !== exp_tms.size()) begin
            errors++; $display("FAIL pause_pulses got %0d exp %0d", lg_tms.size(), exp_tms.size());
        end else begin
            for (int p = 0; p < exp_tms.size(); p++) begin
                checks++;
                if (lg_tms[p] !== exp_tms[p][0] || (exp_tdi[p] != 2 && lg_tdi[p] !== exp_tdi[p][0])) begin
                    errors++; $display("FAIL pause_pin pulse %0d tms/tdi got %b/%b exp %0d/%0d",
                                       p, lg_tms[p], lg_tdi[p], exp_tms[p], exp_tdi[p]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit hdr[13];
        bit [127:0] pay;
        hdr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        foreach (hdr[i]) cyc(1'b1, 1'b0, 1'b0, hdr[i]);
        checks++;
        if (m_tck !== 1'b1) begin errors++; $display("FAIL rstmid_pre_tck got %b exp 1", m_tck); end
        URSTB = 1'b0;
        #1;
        checks++;
        if ({if_a.DUT_TCK, if_a.DUT_TMS, if_a.DUT_TDI, if_a.UTDO} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_outputs tck/tms/tdi/utdo got %b exp 0000",
                               {if_a.DUT_TCK, if_a.DUT_TMS, if_a.DUT_TDI, if_a.UTDO});
        end
        udrsh = 1'b0;
        @(negedge UDRCK);
        URSTB = 1'b1;
        pay = {$urandom, $urandom, $urandom, $urandom};
        drive_packet(0, 1'b0, 5, pay, -1, 1'b1);
        make_model(1'b0, 5, pay);
        checks++;
        if (lg_tms.size() !== exp_tms.size()) begin
            errors++; $display("FAIL rstmid_pulses got %0d exp %0d", lg_tms.size(), exp_tms.size());
        end else begin
            for (int p = 0; p < exp_tms.size(); p++) begin
                checks++;
                if (lg_tms[p] !== exp_tms[p][0] || (exp_tdi[p] != 2 && lg_tdi[p] !== exp_tdi[p][0])) begin
                    errors++; $display("FAIL rstmid_pin pulse %0d tms/tdi got %b/%b exp %0d/%0d",
                                       p, lg_tms[p], lg_tdi[p], exp_tms[p], exp_tdi[p]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_dr_scan();
        test_ir_pad();
        test_len_zero();
        test_unselected();
        test_pause();
        test_reset_mid_pulse();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
